fisc_sequencer: RTL and testbench

Parametrised multicycle control sequencer for the FISC core; the successor to the core's inline state machine. Owns the PC and the latched instruction, and drives the external memory bus with a ready handshake and wait states. Steps each instruction through fetch, decode, execute, memory access and writeback, and performs HALT and interrupt/NMI entry at instruction boundaries. Sits between the memory bus and the decoder/register/ALU datapath.

---
 rtl/fisc_pkg.sv | 19 +
 rtl/fisc_irq_ctrl.sv | 65 ++++++
 rtl/fisc_sequencer.sv | 232 +++++++++++++++++++++++
 tb/tb_fisc_sequencer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/fisc_pkg.sv
// Shared types and default vectors for the FISC control sequencer.
package fisc_pkg;

    typedef enum logic [2:0] {
        COLDSTART = 3'd0,
        FETCH     = 3'd1,
        DECODE    = 3'd2,
        EXECUTE   = 3'd3,
        MEMACCESS = 3'd4,
        WRITEBACK = 3'd5,
        HALTED    = 3'd6,
        INTACK    = 3'd7
    } cpu_state_t;

    localparam logic [63:0] DEF_RESET_VEC = 64'h0;
    localparam logic [63:0] DEF_IRQ_VEC   = 64'h100;
    localparam logic [63:0] DEF_NMI_VEC   = 64'h80;

endpackage

// File: rtl/fisc_irq_ctrl.sv
// Interrupt bookkeeping: NMI falling-edge latch, interrupt enable and
// NMI-over-IRQ priority select for the instruction boundary.
module fisc_irq_ctrl
    import fisc_pkg::*;
#(
    parameter int                ADDR_W  = 64,
    parameter logic [ADDR_W-1:0] IRQ_VEC = ADDR_W'(DEF_IRQ_VEC),
    parameter logic [ADDR_W-1:0] NMI_VEC = ADDR_W'(DEF_NMI_VEC)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              int_n,
    input  logic              nmi_n,
    input  logic              set_ie,
    input  logic              clr_ie,
    input  logic              ack,
    input  logic              ack_nmi,
    output logic              take_nmi,
    output logic              take_irq,
    output logic [ADDR_W-1:0] vector
);

    logic nmi_q_reg;
    logic nmi_pend_reg;
    logic ie_reg;
    logic ie_eff;
    logic nmi_fall;

    assign nmi_fall = nmi_q_reg & ~nmi_n;

    // The boundary decision sees the enable as it will be after this
    // instruction's EI/DI takes effect; DI wins over EI.
    always_comb begin
        ie_eff = ie_reg;
        if (clr_ie)
            ie_eff = 1'b0;
        else if (set_ie)
            ie_eff = 1'b1;
    end

    assign take_nmi = nmi_pend_reg;
    assign take_irq = ~nmi_pend_reg & ie_eff & ~int_n;
    assign vector   = nmi_pend_reg ? NMI_VEC : IRQ_VEC;

    // Edge detection runs regardless of wait_n so a short NMI is never lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            nmi_q_reg    <= 1'b1;
            nmi_pend_reg <= 1'b0;
            ie_reg       <= 1'b0;
        end else begin
            nmi_q_reg <= nmi_n;
            if (nmi_fall)
                nmi_pend_reg <= 1'b1;
            else if (ack && ack_nmi)
                nmi_pend_reg <= 1'b0;

            if (ack || clr_ie)
                ie_reg <= 1'b0;
            else if (set_ie)
                ie_reg <= 1'b1;
        end
    end

endmodule

// File: rtl/fisc_sequencer.sv
// Multicycle FISC control sequencer: owns PC and instruction latch, runs the
// bus handshake and steps F/D/E/M/W with HALT and interrupt entry.
module fisc_sequencer
    import fisc_pkg::*;
#(
    parameter int                ADDR_W    = 64,
    parameter int                DATA_W    = 64,
    parameter int                INSN_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(DEF_RESET_VEC),
    parameter logic [ADDR_W-1:0] IRQ_VEC   = ADDR_W'(DEF_IRQ_VEC),
    parameter logic [ADDR_W-1:0] NMI_VEC   = ADDR_W'(DEF_NMI_VEC)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              int_n,
    input  logic              nmi_n,
    input  logic              wait_n,
    input  logic              rdy,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              dout_en,
    output logic [ADDR_W-1:0] a,
    output logic              rd_n,
    output logic              wr_n,
    output logic              opcycle_n,
    output logic              ioack_n,
    output logic              halt_n,
    output logic [INSN_W-1:0] insn,
    output logic [2:0]        state,
    input  logic              dec_mem,
    input  logic              dec_store,
    input  logic              dec_branch,
    input  logic              dec_halt,
    input  logic              dec_ei,
    input  logic              dec_di,
    input  logic [ADDR_W-1:0] ex_addr,
    input  logic [DATA_W-1:0] ex_wdata,
    output logic              wb_en,
    output logic [DATA_W-1:0] wb_data,
    output logic [ADDR_W-1:0] epc
);

    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(INSN_W / 8);

    cpu_state_t        state_reg;
    logic [ADDR_W-1:0] pc_reg;
    logic [ADDR_W-1:0] a_reg;
    logic [ADDR_W-1:0] epc_reg;
    logic [ADDR_W-1:0] vec_reg;
    logic [DATA_W-1:0] dout_reg;
    logic [DATA_W-1:0] wb_data_reg;
    logic [INSN_W-1:0] insn_reg;
    logic              rd_n_reg;
    logic              wr_n_reg;
    logic              opcycle_n_reg;
    logic              ioack_n_reg;
    logic              halt_n_reg;
    logic              dout_en_reg;
    logic              wb_en_reg;
    logic              entry_nmi_reg;

    logic f_mem_reg;
    logic f_store_reg;
    logic f_branch_reg;
    logic f_halt_reg;
    logic f_ei_reg;
    logic f_di_reg;

    logic              take_nmi;
    logic              take_irq;
    logic [ADDR_W-1:0] vector;
    logic              set_ie;
    logic              clr_ie;
    logic              ack;

    assign set_ie = wait_n && (state_reg == WRITEBACK) && f_ei_reg;
    assign clr_ie = wait_n && (state_reg == WRITEBACK) && f_di_reg;
    assign ack    = wait_n && (state_reg == INTACK);

    fisc_irq_ctrl #(
        .ADDR_W  (ADDR_W),
        .IRQ_VEC (IRQ_VEC),
        .NMI_VEC (NMI_VEC)
    ) u_irq_ctrl (
        .clk      (clk),
        .reset    (reset),
        .int_n    (int_n),
        .nmi_n    (nmi_n),
        .set_ie   (set_ie),
        .clr_ie   (clr_ie),
        .ack      (ack),
        .ack_nmi  (entry_nmi_reg),
        .take_nmi (take_nmi),
        .take_irq (take_irq),
        .vector   (vector)
    );

    // Strobes are set on the edge entering a bus state and cleared on the
    // edge leaving it, so every output here is a flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= COLDSTART;
            pc_reg        <= RESET_VEC;
            a_reg         <= '0;
            epc_reg       <= '0;
            vec_reg       <= '0;
            dout_reg      <= '0;
            wb_data_reg   <= '0;
            insn_reg      <= '0;
            rd_n_reg      <= 1'b1;
            wr_n_reg      <= 1'b1;
            opcycle_n_reg <= 1'b1;
            ioack_n_reg   <= 1'b1;
            halt_n_reg    <= 1'b1;
            dout_en_reg   <= 1'b0;
            wb_en_reg     <= 1'b0;
            entry_nmi_reg <= 1'b0;
            f_mem_reg     <= 1'b0;
            f_store_reg   <= 1'b0;
            f_branch_reg  <= 1'b0;
            f_halt_reg    <= 1'b0;
            f_ei_reg      <= 1'b0;
            f_di_reg      <= 1'b0;
        end else if (wait_n) begin
            wb_en_reg   <= 1'b0;
            ioack_n_reg <= 1'b1;
            unique case (state_reg)
                COLDSTART: begin
                    state_reg     <= FETCH;
                    a_reg         <= pc_reg;
                    rd_n_reg      <= 1'b0;
                    opcycle_n_reg <= 1'b0;
                end
                FETCH: begin
                    if (rdy) begin
                        insn_reg      <= din[INSN_W-1:0];
                        pc_reg        <= pc_reg + PC_STEP;
                        rd_n_reg      <= 1'b1;
                        opcycle_n_reg <= 1'b1;
                        state_reg     <= DECODE;
                    end
                end
                DECODE: begin
                    f_mem_reg    <= dec_mem;
                    f_store_reg  <= dec_store;
                    f_branch_reg <= dec_branch;
                    f_halt_reg   <= dec_halt;
                    f_ei_reg     <= dec_ei;
                    f_di_reg     <= dec_di;
                    state_reg    <= EXECUTE;
                end
                EXECUTE: begin
                    if (f_halt_reg) begin
                        halt_n_reg <= 1'b0;
                        state_reg  <= HALTED;
                    end else if (f_mem_reg) begin
                        a_reg     <= ex_addr;
                        state_reg <= MEMACCESS;
                        if (f_store_reg) begin
                            dout_reg    <= ex_wdata;
                            wr_n_reg    <= 1'b0;
                            dout_en_reg <= 1'b1;
                        end else begin
                            rd_n_reg <= 1'b0;
                        end
                    end else begin
                        if (f_branch_reg)
                            pc_reg <= ex_addr;
                        wb_en_reg <= ~f_branch_reg;
                        state_reg <= WRITEBACK;
                    end
                end
                MEMACCESS: begin
                    if (rdy) begin
                        if (!f_store_reg)
                            wb_data_reg <= din;
                        rd_n_reg    <= 1'b1;
                        wr_n_reg    <= 1'b1;
                        dout_en_reg <= 1'b0;
                        wb_en_reg   <= ~f_store_reg;
                        state_reg   <= WRITEBACK;
                    end
                end
                WRITEBACK: begin
                    if (take_nmi || take_irq) begin
                        vec_reg       <= vector;
                        entry_nmi_reg <= take_nmi;
                        ioack_n_reg   <= 1'b0;
                        state_reg     <= INTACK;
                    end else begin
                        a_reg         <= pc_reg;
                        rd_n_reg      <= 1'b0;
                        opcycle_n_reg <= 1'b0;
                        state_reg     <= FETCH;
                    end
                end
                HALTED: begin
                    if (take_nmi || take_irq) begin
                        vec_reg       <= vector;
                        entry_nmi_reg <= take_nmi;
                        ioack_n_reg   <= 1'b0;
                        halt_n_reg    <= 1'b1;
                        state_reg     <= INTACK;
                    end
                end
                INTACK: begin
                    epc_reg       <= pc_reg;
                    pc_reg        <= vec_reg;
                    a_reg         <= vec_reg;
                    rd_n_reg      <= 1'b0;
                    opcycle_n_reg <= 1'b0;
                    state_reg     <= FETCH;
                end
            endcase
        end
    end

    assign state     = state_reg;
    assign a         = a_reg;
    assign dout      = dout_reg;
    assign dout_en   = dout_en_reg;
    assign rd_n      = rd_n_reg;
    assign wr_n      = wr_n_reg;
    assign opcycle_n = opcycle_n_reg;
    assign ioack_n   = ioack_n_reg;
    assign halt_n    = halt_n_reg;
    assign insn      = insn_reg;
    assign wb_en     = wb_en_reg;
    assign wb_data   = wb_data_reg;
    assign epc       = epc_reg;

endmodule

// File: tb/tb_fisc_sequencer.sv
// Directed bench for fisc_sequencer: walks ALU, branch, load, wait, NMI,
// HALT/IRQ and store-under-reset sequences against hand-computed values.
module tb_fisc_sequencer;
    import fisc_pkg::*;

    logic        clk = 1'b0;
    logic        reset, int_n, nmi_n, wait_n, rdy;
    logic [63:0] din, dout, a, ex_addr, ex_wdata, wb_data, epc;
    logic        dout_en, rd_n, wr_n, opcycle_n, ioack_n, halt_n, wb_en;
    logic [31:0] insn;
    logic [2:0]  state;
    logic        dec_mem, dec_store, dec_branch, dec_halt, dec_ei, dec_di;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fisc_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .int_n      (int_n),
        .nmi_n      (nmi_n),
        .wait_n     (wait_n),
        .rdy        (rdy),
        .din        (din),
        .dout       (dout),
        .dout_en    (dout_en),
        .a          (a),
        .rd_n       (rd_n),
        .wr_n       (wr_n),
        .opcycle_n  (opcycle_n),
        .ioack_n    (ioack_n),
        .halt_n     (halt_n),
        .insn       (insn),
        .state      (state),
        .dec_mem    (dec_mem),
        .dec_store  (dec_store),
        .dec_branch (dec_branch),
        .dec_halt   (dec_halt),
        .dec_ei     (dec_ei),
        .dec_di     (dec_di),
        .ex_addr    (ex_addr),
        .ex_wdata   (ex_wdata),
        .wb_en      (wb_en),
        .wb_data    (wb_data),
        .epc        (epc)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_dec(input logic m, input logic s, input logic b,
                           input logic h, input logic e, input logic d);
        dec_mem = m; dec_store = s; dec_branch = b;
        dec_halt = h; dec_ei = e; dec_di = d;
    endtask

    initial begin
        reset = 1'b1; int_n = 1'b1; nmi_n = 1'b1; wait_n = 1'b1; rdy = 1'b0;
        din = '0; ex_addr = '0; ex_wdata = '0;
        set_dec(0, 0, 0, 0, 0, 0);
        step(); step();
        chk("rst_state",   64'(state), 64'(COLDSTART));
        chk("rst_rd_n",    64'(rd_n), 64'd1);
        chk("rst_wr_n",    64'(wr_n), 64'd1);
        chk("rst_opcyc",   64'(opcycle_n), 64'd1);
        chk("rst_ioack",   64'(ioack_n), 64'd1);
        chk("rst_halt",    64'(halt_n), 64'd1);
        chk("rst_a",       a, 64'd0);
        chk("rst_dout",    dout, 64'd0);
        chk("rst_dout_en", 64'(dout_en), 64'd0);
        chk("rst_wb_en",   64'(wb_en), 64'd0);
        chk("rst_wb_data", wb_data, 64'd0);
        chk("rst_insn",    64'(insn), 64'd0);
        chk("rst_epc",     epc, 64'd0);

        // ALU instruction at 0
        reset = 1'b0; rdy = 1'b1; din = 64'h1234;
        step();
        chk("alu_f_state", 64'(state), 64'(FETCH));
        chk("alu_f_a",     a, 64'h0);
        chk("alu_f_rd_n",  64'(rd_n), 64'd0);
        chk("alu_f_opcyc", 64'(opcycle_n), 64'd0);
        step();
        chk("alu_d_state", 64'(state), 64'(DECODE));
        chk("alu_d_insn",  64'(insn), 64'h1234);
        chk("alu_d_rd_n",  64'(rd_n), 64'd1);
        step();
        chk("alu_e_state", 64'(state), 64'(EXECUTE));
        step();
        chk("alu_w_state", 64'(state), 64'(WRITEBACK));
        chk("alu_w_wb_en", 64'(wb_en), 64'd1);
        step();
        chk("alu_nf_state", 64'(state), 64'(FETCH));
        chk("alu_nf_a",     a, 64'h4);
        chk("alu_nf_wb_en", 64'(wb_en), 64'd0);
        $display("tx alu    insn=%h next_a=%h", insn, a);

        // branch at 4 to 0x300
        din = 64'h2222; set_dec(0, 0, 1, 0, 0, 0); ex_addr = 64'h300;
        step(); step(); step();
        chk("br_w_state", 64'(state), 64'(WRITEBACK));
        chk("br_w_wb_en", 64'(wb_en), 64'd0);
        step();
        chk("br_nf_a", a, 64'h300);
        $display("tx branch insn=%h next_a=%h", insn, a);

        // load at 0x300 from 0x40 with two wait states
        din = 64'h3333; set_dec(1, 0, 0, 0, 0, 0); ex_addr = 64'h40;
        step();
        chk("ld_d_insn", 64'(insn), 64'h3333);
        step(); step();
        chk("ld_m_state", 64'(state), 64'(MEMACCESS));
        chk("ld_m_a",     a, 64'h40);
        chk("ld_m_rd_n0", 64'(rd_n), 64'd0);
        chk("ld_m_opcyc", 64'(opcycle_n), 64'd1);
        rdy = 1'b0; din = 64'hDEAD;
        step();
        chk("ld_m_rd_n1", 64'(rd_n), 64'd0);
        step();
        chk("ld_m_rd_n2", 64'(rd_n), 64'd0);
        rdy = 1'b1;
        step();
        chk("ld_w_state",   64'(state), 64'(WRITEBACK));
        chk("ld_w_wb_data", wb_data, 64'hDEAD);
        chk("ld_w_wb_en",   64'(wb_en), 64'd1);
        chk("ld_w_rd_n",    64'(rd_n), 64'd1);
        step();
        chk("ld_nf_state", 64'(state), 64'(FETCH));
        chk("ld_nf_a",     a, 64'h304);
        $display("tx load   addr=40 data=%h next_a=%h", wb_data, a);

        // wait_n held low through a ready fetch; this instruction also sets ie
        din = 64'h5678; set_dec(0, 0, 0, 0, 1, 0); wait_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("wt_state", 64'(state), 64'(FETCH));
            chk("wt_a",     a, 64'h304);
            chk("wt_rd_n",  64'(rd_n), 64'd0);
            chk("wt_insn",  64'(insn), 64'h3333);
        end
        wait_n = 1'b1;
        step();
        chk("wt_d_state", 64'(state), 64'(DECODE));
        chk("wt_d_insn",  64'(insn), 64'h5678);
        step(); step(); step();
        chk("wt_nf_a", a, 64'h308);
        $display("tx wait   insn=%h next_a=%h", insn, a);

        // NMI and IRQ fall together during EXECUTE
        din = 64'h9999; set_dec(0, 0, 0, 0, 0, 0);
        step(); step();
        chk("nmi_e_state", 64'(state), 64'(EXECUTE));
        int_n = 1'b0; nmi_n = 1'b0;
        step();
        chk("nmi_w_state", 64'(state), 64'(WRITEBACK));
        step();
        chk("nmi_ack_state", 64'(state), 64'(INTACK));
        chk("nmi_ack_ioack", 64'(ioack_n), 64'd0);
        nmi_n = 1'b1; din = 64'hAAAA;
        step();
        chk("nmi_f_state", 64'(state), 64'(FETCH));
        chk("nmi_f_a",     a, 64'h80);
        chk("nmi_f_epc",   epc, 64'h30C);
        chk("nmi_f_ioack", 64'(ioack_n), 64'd1);
        step(); step(); step(); step();
        chk("nmi_masked_state", 64'(state), 64'(FETCH));
        chk("nmi_masked_a",     a, 64'h84);
        int_n = 1'b1;
        $display("tx nmi    epc=%h next_a=%h", epc, a);

        // EI, then HALT, then IRQ wakes it
        din = 64'hBBBB; set_dec(0, 0, 0, 0, 1, 0);
        step(); step(); step(); step();
        chk("ei_nf_a", a, 64'h88);
        din = 64'hCCCC; set_dec(0, 0, 0, 1, 0, 0);
        step(); step(); step();
        chk("hlt_state", 64'(state), 64'(HALTED));
        chk("hlt_halt_n", 64'(halt_n), 64'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("hlt_stay", 64'(halt_n), 64'd0);
        end
        int_n = 1'b0;
        step();
        chk("hlt_ack_state", 64'(state), 64'(INTACK));
        chk("hlt_ack_ioack", 64'(ioack_n), 64'd0);
        chk("hlt_ack_halt",  64'(halt_n), 64'd1);
        int_n = 1'b1;
        step();
        chk("irq_f_a",   a, 64'h100);
        chk("irq_f_epc", epc, 64'h8C);
        $display("tx halt   epc=%h next_a=%h", epc, a);

        // store interrupted by reset mid-transfer
        din = 64'hDDDD; set_dec(1, 1, 0, 0, 0, 0);
        ex_addr = 64'h200; ex_wdata = 64'hBEEF;
        step(); step(); step();
        chk("st_m_state",   64'(state), 64'(MEMACCESS));
        chk("st_m_wr_n",    64'(wr_n), 64'd0);
        chk("st_m_rd_n",    64'(rd_n), 64'd1);
        chk("st_m_dout_en", 64'(dout_en), 64'd1);
        chk("st_m_dout",    dout, 64'hBEEF);
        chk("st_m_a",       a, 64'h200);
        rdy = 1'b0;
        step();
        chk("st_m_hold", 64'(wr_n), 64'd0);
        reset = 1'b1;
        step();
        chk("st_rst_wr_n",    64'(wr_n), 64'd1);
        chk("st_rst_dout_en", 64'(dout_en), 64'd0);
        chk("st_rst_state",   64'(state), 64'(COLDSTART));
        chk("st_rst_a",       a, 64'h0);
        reset = 1'b0; rdy = 1'b1; set_dec(0, 0, 0, 0, 0, 0);
        step();
        chk("st_restart_state", 64'(state), 64'(FETCH));
        chk("st_restart_a",     a, 64'h0);
        $display("tx store  reset mid-transfer wr_n=%0d", wr_n);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
